// File: rtl/enemy_spawner_if.sv
// Spawner bus: game control, tick and shot inputs, enemy/score outputs.
// The slave modport is the spawner; the master modport is its driver/observer.
interface enemy_spawner_if;
  logic       start;
  logic       spawn_tick;
  logic       shot_valid;
  logic [2:0] shot_slot;
  logic       shot_ready;
  logic       enemy_valid;
  logic [2:0] enemy_slot;
  logic [8:0] enemy_x;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] hits;
  logic [7:0] misses;
  logic       game_over;

  modport master (
    output start, spawn_tick, shot_valid, shot_slot,
    input  shot_ready, enemy_valid, enemy_slot, enemy_x,
           hit_pulse, miss_pulse, hits, misses, game_over
  );

  modport slave (
    input  start, spawn_tick, shot_valid, shot_slot,
    output shot_ready, enemy_valid, enemy_slot, enemy_x,
           hit_pulse, miss_pulse, hits, misses, game_over
  );
endinterface

// File: rtl/enemy_spawner.sv
// Enemy spawner: places one enemy per tick in an LFSR-chosen slot, scores hits/misses.
// All outputs registered, one-edge latency; shots accepted only in ACTIVE. Option: ENEMY_SPAWN_NOREPEAT_EN.
module enemy_spawner #(
  parameter int         NUM_SLOTS      = 8,
  parameter int         LIFETIME_TICKS = 3,
  parameter int         MAX_MISSES     = 5,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         X_BASE         = 16,
  parameter int         X_STEP         = 36
) (
  input  logic           i_clock,
  input  logic           i_reset,
  enemy_spawner_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [3:0] AGE_LAST   = 4'(LIFETIME_TICKS - 1);
  localparam logic [7:0] MISS_LIMIT = 8'(MAX_MISSES);

  state_t     r_state;
  logic [7:0] r_lfsr;
  logic [3:0] r_age;
  logic [2:0] r_slot;
  logic [8:0] r_x;
  logic       r_shot_ready;
  logic       r_enemy_valid;
  logic       r_hit_pulse;
  logic       r_miss_pulse;
  logic [7:0] r_hits;
  logic [7:0] r_misses;
  logic       r_game_over;
`ifdef ENEMY_SPAWN_NOREPEAT_EN
  logic [2:0] r_prev_slot;
`endif

  logic [7:0] w_lfsr_next;
  logic       w_lfsr_run;
  logic [2:0] w_spawn_slot;
  logic [8:0] w_spawn_x;
  logic       w_hit;
  logic       w_expire;
  logic [7:0] w_hits_inc;
  logic [7:0] w_misses_inc;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_lfsr_run  = (r_state == S_WAIT) || (r_state == S_ACTIVE);

`ifdef ENEMY_SPAWN_NOREPEAT_EN
  // Bump to the neighbouring slot so the same slot never appears twice in a row.
  assign w_spawn_slot = (r_lfsr[2:0] == r_prev_slot) ? r_lfsr[2:0] + 3'd1 : r_lfsr[2:0];
`else
  assign w_spawn_slot = r_lfsr[2:0];
`endif

  assign w_spawn_x    = 9'(X_BASE) + 9'(w_spawn_slot) * 9'(X_STEP);
  assign w_hit        = (r_state == S_ACTIVE) && bus.shot_valid && (bus.shot_slot == r_slot);
  assign w_expire     = (r_age == AGE_LAST);
  assign w_hits_inc   = (r_hits == 8'hFF) ? r_hits : r_hits + 8'd1;
  assign w_misses_inc = r_misses + 8'd1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_lfsr        <= LFSR_SEED;
      r_age         <= 4'd0;
      r_slot        <= 3'd0;
      r_x           <= 9'd0;
      r_shot_ready  <= 1'b0;
      r_enemy_valid <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_hits        <= 8'd0;
      r_misses      <= 8'd0;
      r_game_over   <= 1'b0;
`ifdef ENEMY_SPAWN_NOREPEAT_EN
      r_prev_slot   <= 3'd0;
`endif
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      if (w_lfsr_run) begin
        r_lfsr <= w_lfsr_next;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_WAIT;
            r_hits   <= 8'd0;
            r_misses <= 8'd0;
            r_age    <= 4'd0;
          end
        end

        S_WAIT: begin
          if (!bus.start) begin
            r_state <= S_IDLE;
          end else if (bus.spawn_tick) begin
            r_state       <= S_ACTIVE;
            r_slot        <= w_spawn_slot;
            r_x           <= w_spawn_x;
            r_age         <= 4'd0;
            r_enemy_valid <= 1'b1;
            r_shot_ready  <= 1'b1;
`ifdef ENEMY_SPAWN_NOREPEAT_EN
            r_prev_slot   <= w_spawn_slot;
`endif
          end
        end

        S_ACTIVE: begin
          if (!bus.start) begin
            r_state       <= S_IDLE;
            r_enemy_valid <= 1'b0;
            r_shot_ready  <= 1'b0;
          end else if (w_hit) begin
            // A hit in the same cycle as a tick swallows the tick.
            r_state       <= S_WAIT;
            r_hits        <= w_hits_inc;
            r_hit_pulse   <= 1'b1;
            r_enemy_valid <= 1'b0;
            r_shot_ready  <= 1'b0;
          end else if (bus.spawn_tick) begin
            if (w_expire) begin
              r_misses      <= w_misses_inc;
              r_miss_pulse  <= 1'b1;
              r_enemy_valid <= 1'b0;
              r_shot_ready  <= 1'b0;
              if (w_misses_inc == MISS_LIMIT) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state     <= S_WAIT;
              end
            end else begin
              r_age <= r_age + 4'd1;
            end
          end
        end

        S_OVER: begin
          if (!bus.start) begin
            r_state     <= S_IDLE;
            r_game_over <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.shot_ready  = r_shot_ready;
  assign bus.enemy_valid = r_enemy_valid;
  assign bus.enemy_slot  = r_slot;
  assign bus.enemy_x     = r_x;
  assign bus.hit_pulse   = r_hit_pulse;
  assign bus.miss_pulse  = r_miss_pulse;
  assign bus.hits        = r_hits;
  assign bus.misses      = r_misses;
  assign bus.game_over   = r_game_over;

endmodule
